// File: rtl/fetch_unit.sv
// fetch_unit: PC holder and instruction-fetch initiator for a single-cycle,
// combinational-read instruction memory. The fetched word and its PC go to
// decode over a valid/ready handshake. Execute can redirect the PC; a
// misaligned redirect target puts the unit in a terminal fault state.
module fetch_unit #(
  parameter int                    ADDR_WIDTH = 32,
  parameter logic [ADDR_WIDTH-1:0] RESET_PC   = '0,
  parameter logic [31:0]           NOP_INSTR  = 32'h0000_0013
) (
  input  logic                  clk,
  input  logic                  rst_n,
  output logic [ADDR_WIDTH-1:0] imem_addr,
  input  logic [31:0]           imem_data,
  output logic                  inst_valid,
  input  logic                  inst_ready,
  output logic [31:0]           inst_data,
  output logic [ADDR_WIDTH-1:0] inst_pc,
  input  logic                  redirect_valid,
  input  logic [ADDR_WIDTH-1:0] redirect_pc,
  output logic                  fault,
  output logic [31:0]           fetch_count
);

  typedef enum logic [1:0] {BOOT, FETCH, FAULT} state_t;

  state_t                state;
  logic [ADDR_WIDTH-1:0] pc;
  logic                  load;
  logic                  redir_mis;
  logic                  xfer;

  // The memory address comes straight from the PC register only.
  assign imem_addr = pc;
  assign load      = !inst_valid || inst_ready;
  assign redir_mis = |redirect_pc[1:0];
  assign xfer      = inst_valid && inst_ready;

  // Fetch FSM, PC, output register and handshake counter.
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      state       <= BOOT;
      pc          <= RESET_PC;
      inst_valid  <= 1'b0;
      inst_data   <= NOP_INSTR;
      inst_pc     <= '0;
      fault       <= 1'b0;
      fetch_count <= '0;
    end else begin
      // A handshake in the same cycle as a redirect still completes.
      if (xfer) fetch_count <= fetch_count + 32'd1;

      case (state)
        // Memory is not read during the first cycle out of reset.
        BOOT: begin
          if (redirect_valid) begin
            pc <= redirect_pc;
            if (redir_mis) begin
              fault <= 1'b1;
              state <= FAULT;
            end else begin
              state <= FETCH;
            end
          end else begin
            state <= FETCH;
          end
        end

        // Redirect wins over both load and stall; it flushes the held word.
        FETCH: begin
          if (redirect_valid) begin
            pc         <= redirect_pc;
            inst_valid <= 1'b0;
            inst_data  <= NOP_INSTR;
            if (redir_mis) begin
              fault <= 1'b1;
              state <= FAULT;
            end
          end else if (load) begin
            inst_data  <= imem_data;
            inst_pc    <= pc;
            inst_valid <= 1'b1;
            pc         <= pc + ADDR_WIDTH'(4);
          end
        end

        // Terminal until reset: no loads, redirects ignored.
        FAULT: begin
          inst_valid <= 1'b0;
        end

        default: state <= FAULT;
      endcase
    end
  end

endmodule
